// File: rtl/regfile_wr_arbiter_pkg.sv
// ============================================================================
// Module   : regfile_pkg
// Brief    : Shared register-file constants and the writeback request record.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int                    REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] XZR_ADDR   = 5'd31;
    localparam int                    REG_DATA_W = 64;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wr_req_t;

endpackage : regfile_pkg

`default_nettype wire

// File: rtl/regfile_wr_arbiter_if.sv
// ============================================================================
// Module   : regfile_wr_arbiter_if
// Brief    : Writeback requester handshakes plus the register-file write port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_wr_arbiter_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
);

    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              wr_hold;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    // Requesters and the register file side.
    modport master (
        output req0_valid, req0_addr, req0_data,
        input  req0_ready,
        output req1_valid, req1_addr, req1_data,
        input  req1_ready,
        output wr_hold,
        input  wr_en, wr_addr, wr_data
    );

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_addr, req0_data,
        output req0_ready,
        input  req1_valid, req1_addr, req1_data,
        output req1_ready,
        input  wr_hold,
        output wr_en, wr_addr, wr_data
    );

endinterface : regfile_wr_arbiter_if

`default_nettype wire

// File: rtl/regfile_wr_arbiter_rr_arb2.sv
// ============================================================================
// Module   : rr_arb2
// Brief    : Two-way round-robin grant with its priority flop.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2
    import regfile_pkg::*;
(
    input  wire logic       clk_i,
    input  wire logic       rst_ni,
    input  wire logic [1:0] req_i,
    input  wire logic       hold_i,
    output logic      [1:0] gnt_o
);

    logic prio_q;
    logic prio_d;

    always_comb begin
        gnt_o  = 2'b00;
        prio_d = prio_q;
        // Grants are masked while reset is asserted so no handshake completes.
        if (rst_ni && !hold_i) begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = prio_q ? 2'b10 : 2'b01;
                default: gnt_o = 2'b00;
            endcase
        end
        if (gnt_o[0]) begin
            prio_d = 1'b1;
        end else if (gnt_o[1]) begin
            prio_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule : rr_arb2

`default_nettype wire

// File: rtl/regfile_wr_arbiter.sv
// ============================================================================
// Module   : regfile_wr_arbiter
// Brief    : Shares the register-file write port between ALU and load writeback.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  wire logic             clk_i,
    input  wire logic             rst_ni,
    regfile_wr_arbiter_if.slave   bus,
    output logic      [CNT_W-1:0] conflict_cnt_o
);

    logic [1:0]        w_gnt;
    logic              w_xfer;
    logic              w_deny;
    logic [ADDR_W-1:0] w_win_addr;
    logic [DATA_W-1:0] w_win_data;

    logic              wr_en_q,   wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;

    rr_arb2 u_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  ({bus.req1_valid, bus.req0_valid}),
        .hold_i (bus.wr_hold),
        .gnt_o  (w_gnt)
    );

    assign bus.req0_ready = w_gnt[0];
    assign bus.req1_ready = w_gnt[1];
    assign w_xfer         = |w_gnt;
    assign w_deny         = (bus.req0_valid && !w_gnt[0]) || (bus.req1_valid && !w_gnt[1]);

    always_comb begin
        w_win_addr = bus.req0_addr;
        w_win_data = bus.req0_data;
        if (w_gnt[1]) begin
            w_win_addr = bus.req1_addr;
            w_win_data = bus.req1_data;
        end
    end

    always_comb begin
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        cnt_d     = cnt_q;
        // Zero-register writes still load the stage but never raise the enable.
        wr_en_d   = w_xfer && (w_win_addr != ADDR_W'(XZR_ADDR));
        if (w_xfer) begin
            wr_addr_d = w_win_addr;
            wr_data_d = w_win_data;
        end
        if (w_deny && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            cnt_q     <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign conflict_cnt_o = cnt_q;

endmodule : regfile_wr_arbiter

`default_nettype wire

// File: tb/tb_regfile_wr_arbiter.sv
// ============================================================================
// Module   : tb_regfile_wr_arbiter
// Brief    : Directed vector table plus reset/saturation sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_wr_arbiter;
    import regfile_pkg::*;

    typedef struct {
        logic        v0;
        logic [4:0]  a0;
        logic [63:0] d0;
        logic        v1;
        logic [4:0]  a1;
        logic [63:0] d1;
        logic        hold;
        logic        r0;
        logic        r1;
        logic        en;
        logic [4:0]  waddr;
        logic [63:0] wdata;
        logic [15:0] cnt;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] cnt;
    int          n_vec;
    int          n_err;
    vec_t        vecs[16];

    regfile_wr_arbiter_if #(.DATA_W(64), .ADDR_W(5)) bus ();

    regfile_wr_arbiter #(.DATA_W(64), .ADDR_W(5), .CNT_W(16)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .bus            (bus),
        .conflict_cnt_o (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic v0, input logic [4:0] a0, input logic [63:0] d0,
                                input logic v1, input logic [4:0] a1, input logic [63:0] d1,
                                input logic hold, input logic r0, input logic r1, input logic en,
                                input logic [4:0] waddr, input logic [63:0] wdata,
                                input logic [15:0] c);
        vec_t v;
        v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1; v.hold = hold;
        v.r0 = r0; v.r1 = r1; v.en = en; v.waddr = waddr; v.wdata = wdata; v.cnt = c;
        return v;
    endfunction

    task automatic drive(input logic v0, input logic [4:0] a0, input logic [63:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [63:0] d1,
                         input logic hold);
        bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
        bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
        bus.wr_hold    = hold;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        // Outputs listed are: ready this cycle, then stage/counter after the edge.
        vecs[0]  = mk(1, 1, 64'h100, 1, 11, 64'h200, 0, 1, 0, 1,  1, 64'h100, 1);
        vecs[1]  = mk(1, 2, 64'h101, 1, 11, 64'h200, 0, 0, 1, 1, 11, 64'h200, 2);
        vecs[2]  = mk(1, 2, 64'h101, 1, 12, 64'h201, 0, 1, 0, 1,  2, 64'h101, 3);
        vecs[3]  = mk(1, 3, 64'h102, 1, 12, 64'h201, 0, 0, 1, 1, 12, 64'h201, 4);
        vecs[4]  = mk(0, 0, 64'h0,   0, 0,  64'h0,   0, 0, 0, 0, 12, 64'h201, 4);
        vecs[5]  = mk(1, 3, 64'hDEAD_BEEF_0000_0001, 0, 0, 64'h0, 0, 1, 0, 1, 3, 64'hDEAD_BEEF_0000_0001, 4);
        vecs[6]  = mk(0, 0, 64'h0,   0, 0,  64'h0,   0, 0, 0, 0,  3, 64'hDEAD_BEEF_0000_0001, 4);
        vecs[7]  = mk(0, 0, 64'h0,   1, 31, 64'h55,  0, 0, 1, 0, 31, 64'h55,  4);
        vecs[8]  = mk(1, 5, 64'h5,   1, 6,  64'h6,   0, 1, 0, 1,  5, 64'h5,   5);
        vecs[9]  = mk(0, 0, 64'h0,   1, 6,  64'h6,   0, 0, 1, 1,  6, 64'h6,   5);
        vecs[10] = mk(1, 7, 64'h7,   0, 0,  64'h0,   1, 0, 0, 0,  6, 64'h6,   6);
        vecs[11] = mk(1, 7, 64'h7,   0, 0,  64'h0,   1, 0, 0, 0,  6, 64'h6,   7);
        vecs[12] = mk(1, 7, 64'h7,   0, 0,  64'h0,   1, 0, 0, 0,  6, 64'h6,   8);
        vecs[13] = mk(1, 7, 64'h7,   0, 0,  64'h0,   0, 1, 0, 1,  7, 64'h7,   8);
        vecs[14] = mk(1, 8, 64'h8,   1, 9,  64'h9,   1, 0, 0, 0,  7, 64'h7,   9);
        vecs[15] = mk(0, 0, 64'h0,   0, 0,  64'h0,   0, 0, 0, 0,  7, 64'h7,   9);

        // Reset asserted with both requesters valid.
        rst_n = 1'b0;
        drive(1, 1, 64'h100, 1, 11, 64'h200, 0);
        #1;
        n_vec++;
        chk("rst_r0", 64'(bus.req0_ready), 64'd0);
        chk("rst_r1", 64'(bus.req1_ready), 64'd0);
        chk("rst_en", 64'(bus.wr_en), 64'd0);
        chk("rst_addr", 64'(bus.wr_addr), 64'd0);
        chk("rst_data", bus.wr_data, 64'd0);
        chk("rst_cnt", 64'(cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].v0, vecs[i].a0, vecs[i].d0, vecs[i].v1, vecs[i].a1, vecs[i].d1, vecs[i].hold);
            #1;
            n_vec++;
            chk($sformatf("v%0d_r0", i), 64'(bus.req0_ready), 64'(vecs[i].r0));
            chk($sformatf("v%0d_r1", i), 64'(bus.req1_ready), 64'(vecs[i].r1));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_en", i), 64'(bus.wr_en), 64'(vecs[i].en));
            chk($sformatf("v%0d_addr", i), 64'(bus.wr_addr), 64'(vecs[i].waddr));
            chk($sformatf("v%0d_data", i), bus.wr_data, vecs[i].wdata);
            chk($sformatf("v%0d_cnt", i), 64'(cnt), 64'(vecs[i].cnt));
            @(negedge clk);
        end

        // Reset the cycle after a grant: in-flight write dropped, counter cleared.
        drive(1, 9, 64'h99, 0, 0, 64'h0, 0);
        #1;
        n_vec++;
        chk("mid_r0", 64'(bus.req0_ready), 64'd1);
        @(posedge clk);
        #1;
        chk("mid_en_pre", 64'(bus.wr_en), 64'd1);
        chk("mid_addr_pre", 64'(bus.wr_addr), 64'd9);
        rst_n = 1'b0;
        drive(1, 9, 64'h99, 1, 10, 64'hAA, 0);
        #1;
        chk("mid_en", 64'(bus.wr_en), 64'd0);
        chk("mid_addr", 64'(bus.wr_addr), 64'd0);
        chk("mid_cnt", 64'(cnt), 64'd0);
        chk("mid_r0_rst", 64'(bus.req0_ready), 64'd0);
        chk("mid_r1_rst", 64'(bus.req1_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("mid_en_held", 64'(bus.wr_en), 64'd0);
        chk("mid_cnt_held", 64'(cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_r0", 64'(bus.req0_ready), 64'd1);
        chk("post_rst_r1", 64'(bus.req1_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("post_rst_en", 64'(bus.wr_en), 64'd1);
        chk("post_rst_addr", 64'(bus.wr_addr), 64'd9);
        chk("post_rst_data", bus.wr_data, 64'h99);
        chk("post_rst_cnt", 64'(cnt), 64'd1);

        // Saturation: hold with req0 valid accrues one denial per cycle.
        @(negedge clk);
        drive(1, 4, 64'h44, 0, 0, 64'h0, 1);
        n_vec++;
        repeat (16'hFFFD) @(posedge clk);
        #1;
        chk("sat_fffe", 64'(cnt), 64'hFFFE);
        repeat (3) @(posedge clk);
        #1;
        chk("sat_ffff", 64'(cnt), 64'hFFFF);
        chk("sat_en", 64'(bus.wr_en), 64'd0);
        @(negedge clk);
        bus.wr_hold = 1'b0;
        #1;
        chk("sat_r0", 64'(bus.req0_ready), 64'd1);
        @(posedge clk);
        #1;
        chk("sat_hold_cnt", 64'(cnt), 64'hFFFF);
        chk("sat_wr_en", 64'(bus.wr_en), 64'd1);
        chk("sat_wr_addr", 64'(bus.wr_addr), 64'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_regfile_wr_arbiter

`default_nettype wire
